ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have inputs: ID_EX_A  in  8  operand A; ID_EX_B  in  8  operand B / store data.
REQ-004 SHALL have input: ID_EX_instruction  in  19  decoded instruction; bits [7:0] are the immediate.
REQ-005 SHALL have control inputs, 1 bit each: ID_EX_mem_write, ID_EX_reg_write, ID_EX_alu_use_carry, ID_EX_alu_in_mux, ID_EX_select_c, ID_EX_select_z, ID_EX_write_c, ID_EX_write_z.
REQ-006 SHALL have inputs: ID_EX_alu_op  in  3  ALU operation; ID_EX_reg_write_mux  in  2  writeback source select.
REQ-007 SHALL have inputs: stall  in  1  hold EX_MEM register and flags; flush  in  1  inject bubble.
REQ-008 SHALL have outputs: EX_MEM_result  out  8; EX_MEM_B  out  8; EX_MEM_instruction  out  19.
REQ-009 SHALL have outputs: EX_MEM_mem_write  out  1; EX_MEM_reg_write  out  1; EX_MEM_reg_write_mux  out  2.
REQ-010 SHALL have outputs: c_flag  out  1  committed carry; z_flag  out  1  committed zero.

Function
REQ-011 Operand OB SHALL be ID_EX_B when alu_in_mux=0, instruction[7:0] when 1; cin = alu_use_carry ? c_flag : 0.
REQ-012 alu_op 000 ADD: {cout,res} = A + OB + cin, 9-bit sum, cout = bit 8.
REQ-013 alu_op 001 SUB: res = (A - OB - cin) mod 256; cout = 1 iff A < OB + cin (borrow).
REQ-014 alu_op 010/011/100 AND/OR/XOR: res = A op OB; cout = 0.
REQ-015 alu_op 101 SHL: res = {A[6:0],cin}, cout = A[7]; 110 SHR: res = {cin,A[7:1]}, cout = A[0].
REQ-016 alu_op 111 PASS: res = OB; cout = 0.
REQ-017 Carry next value SHALL be cout when select_c=1, 0 when select_c=0; written only when write_c=1.
REQ-018 Zero next value SHALL be (res==0) when select_z=1, (res==0) AND z_flag when select_z=0 (chained compare); written only when write_z=1.
REQ-019 Flag and EX_MEM update occurs when stall=0 and flush=0; latency one cycle from ID_EX inputs to EX_MEM outputs and flags.
REQ-020 stall=1, flush=0: EX_MEM outputs and both flags SHALL hold; a stalled instruction SHALL update flags exactly once, on its non-stalled cycle.
REQ-021 flush=1 (priority over stall): next cycle EX_MEM_mem_write=0, EX_MEM_reg_write=0, EX_MEM_reg_write_mux=0, EX_MEM_result=0, EX_MEM_B=0, EX_MEM_instruction=0; flags hold.
REQ-022 EX_MEM_B SHALL carry ID_EX_B unmodified (store data), never the immediate.
REQ-023 Back-to-back dependent flag ops SHALL see the flag written by the previous instruction (cin/z_flag read from committed register, no extra cycle).
REQ-024 Arithmetic is unsigned modulo 256; no overflow flag exists.

Reset
REQ-025 On rising clk with reset=0, all EX_MEM outputs, c_flag and z_flag SHALL become 0, overriding stall and flush.
REQ-026 Reset mid-operation SHALL discard any in-flight or stalled instruction; first post-reset cycle loads normally.
REQ-027 Outputs SHALL be undefined-free (0) from the first reset edge; no asynchronous path from reset.

Verification
REQ-028 ADD, A=0xF0, B=0x20, use_carry=0, select_c=1, write_c=1, write_z=1, select_z=1 -> result=0x10, c_flag=1, z_flag=0.
REQ-029 Following cycle ADD with use_carry=1, A=0x00, B=0x00 -> result=0x01, c_flag=0 (chain uses prior carry).
REQ-030 SUB, A=0x05, imm=0x05, alu_in_mux=1, select_z=1 -> result=0x00, z_flag=1, c_flag=0; then SUB A=0x03, imm=0x04, select_z=0 -> result=0xFF, c_flag=1, z_flag=0.
REQ-031 SHR A=0x81, cin=0 with stall=1 for 3 cycles then 0 -> outputs/flags frozen 3 cycles, then result=0x40, c_flag=1, set once.
REQ-032 flush=1 with stall=1 and reg_write=1, mem_write=1 -> next cycle all EX_MEM outputs 0, flags unchanged.
REQ-033 reset=0 asserted during stall with c_flag=1 -> next edge all outputs 0, c_flag=0, z_flag=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX stage ALU with carry/zero flag registers and the EX/MEM pipeline register.
// Flags are read from the committed registers, so dependent ops chain with no bubble.
module ex_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ID_EX_A,
    input  logic [7:0]  ID_EX_B,
    input  logic [18:0] ID_EX_instruction,
    input  logic        ID_EX_mem_write,
    input  logic        ID_EX_reg_write,
    input  logic        ID_EX_alu_use_carry,
    input  logic        ID_EX_alu_in_mux,
    input  logic        ID_EX_select_c,
    input  logic        ID_EX_select_z,
    input  logic        ID_EX_write_c,
    input  logic        ID_EX_write_z,
    input  logic [2:0]  ID_EX_alu_op,
    input  logic [1:0]  ID_EX_reg_write_mux,
    input  logic        stall,
    input  logic        flush,
    output logic [7:0]  EX_MEM_result,
    output logic [7:0]  EX_MEM_B,
    output logic [18:0] EX_MEM_instruction,
    output logic        EX_MEM_mem_write,
    output logic        EX_MEM_reg_write,
    output logic [1:0]  EX_MEM_reg_write_mux,
    output logic        c_flag,
    output logic        z_flag
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic [7:0]  res_q, b_q;
    logic [18:0] ins_q;
    logic        mw_q, rw_q, c_q, z_q;
    logic [1:0]  rwm_q;

    logic [7:0]  ob, res_d;
    logic [8:0]  wide;
    logic        cin, cout, zero, c_d, z_d;

    always_comb begin
        ob    = ID_EX_alu_in_mux ? ID_EX_instruction[7:0] : ID_EX_B;
        cin   = ID_EX_alu_use_carry & c_q;
        wide  = 9'd0;
        res_d = 8'd0;
        cout  = 1'b0;
        unique case (ID_EX_alu_op)
            OP_ADD: begin
                wide  = {1'b0, ID_EX_A} + {1'b0, ob} + {8'd0, cin};
                res_d = wide[7:0];
                cout  = wide[8];
            end
            OP_SUB: begin
                // bit 8 of the 9-bit difference is the borrow
                wide  = {1'b0, ID_EX_A} - {1'b0, ob} - {8'd0, cin};
                res_d = wide[7:0];
                cout  = wide[8];
            end
            OP_AND:  res_d = ID_EX_A & ob;
            OP_OR:   res_d = ID_EX_A | ob;
            OP_XOR:  res_d = ID_EX_A ^ ob;
            OP_SHL: begin
                res_d = {ID_EX_A[6:0], cin};
                cout  = ID_EX_A[7];
            end
            OP_SHR: begin
                res_d = {cin, ID_EX_A[7:1]};
                cout  = ID_EX_A[0];
            end
            OP_PASS: res_d = ob;
        endcase
        zero = (res_d == 8'd0);
        c_d  = ID_EX_write_c ? (ID_EX_select_c & cout) : c_q;
        z_d  = ID_EX_write_z ? (zero & (ID_EX_select_z | z_q)) : z_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            res_q <= 8'd0;
            b_q   <= 8'd0;
            ins_q <= 19'd0;
            mw_q  <= 1'b0;
            rw_q  <= 1'b0;
            rwm_q <= 2'd0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
        end else if (flush) begin
            res_q <= 8'd0;
            b_q   <= 8'd0;
            ins_q <= 19'd0;
            mw_q  <= 1'b0;
            rw_q  <= 1'b0;
            rwm_q <= 2'd0;
        end else if (!stall) begin
            res_q <= res_d;
            b_q   <= ID_EX_B;
            ins_q <= ID_EX_instruction;
            mw_q  <= ID_EX_mem_write;
            rw_q  <= ID_EX_reg_write;
            rwm_q <= ID_EX_reg_write_mux;
            c_q   <= c_d;
            z_q   <= z_d;
        end
    end

    assign EX_MEM_result        = res_q;
    assign EX_MEM_B             = b_q;
    assign EX_MEM_instruction   = ins_q;
    assign EX_MEM_mem_write     = mw_q;
    assign EX_MEM_reg_write     = rw_q;
    assign EX_MEM_reg_write_mux = rwm_q;
    assign c_flag               = c_q;
    assign z_flag               = z_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: vector table plus stall/flush/reset sequences,
// expected records queued at drive time and popped after the capturing edge.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ID_EX_A, ID_EX_B;
    logic [18:0] ID_EX_instruction;
    logic        ID_EX_mem_write, ID_EX_reg_write, ID_EX_alu_use_carry;
    logic        ID_EX_alu_in_mux, ID_EX_select_c, ID_EX_select_z;
    logic        ID_EX_write_c, ID_EX_write_z;
    logic [2:0]  ID_EX_alu_op;
    logic [1:0]  ID_EX_reg_write_mux;
    logic        stall, flush;
    logic [7:0]  EX_MEM_result, EX_MEM_B;
    logic [18:0] EX_MEM_instruction;
    logic        EX_MEM_mem_write, EX_MEM_reg_write;
    logic [1:0]  EX_MEM_reg_write_mux;
    logic        c_flag, z_flag;

    ex_mem_stage dut (
        .clk(clk), .reset(reset),
        .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B),
        .ID_EX_instruction(ID_EX_instruction),
        .ID_EX_mem_write(ID_EX_mem_write),
        .ID_EX_reg_write(ID_EX_reg_write),
        .ID_EX_alu_use_carry(ID_EX_alu_use_carry),
        .ID_EX_alu_in_mux(ID_EX_alu_in_mux),
        .ID_EX_select_c(ID_EX_select_c),
        .ID_EX_select_z(ID_EX_select_z),
        .ID_EX_write_c(ID_EX_write_c),
        .ID_EX_write_z(ID_EX_write_z),
        .ID_EX_alu_op(ID_EX_alu_op),
        .ID_EX_reg_write_mux(ID_EX_reg_write_mux),
        .stall(stall), .flush(flush),
        .EX_MEM_result(EX_MEM_result), .EX_MEM_B(EX_MEM_B),
        .EX_MEM_instruction(EX_MEM_instruction),
        .EX_MEM_mem_write(EX_MEM_mem_write),
        .EX_MEM_reg_write(EX_MEM_reg_write),
        .EX_MEM_reg_write_mux(EX_MEM_reg_write_mux),
        .c_flag(c_flag), .z_flag(z_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  res;
        logic [7:0]  b;
        logic [18:0] ins;
        logic        mw;
        logic        rw;
        logic [1:0]  rwm;
        logic        c;
        logic        z;
    } out_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b, imm;
        logic       mux, uc, sc, wc, sz, wz;
        logic [7:0] eres;
        logic       ec, ez;
    } vec_t;

    out_t sbq[$];
    out_t last;
    vec_t vecs[14];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(logic [2:0] op, logic [7:0] a, logic [7:0] b,
                                logic [7:0] imm, logic mux, logic uc,
                                logic sc, logic wc, logic sz, logic wz,
                                logic [7:0] eres, logic ec, logic ez);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.imm = imm; v.mux = mux; v.uc = uc;
        v.sc = sc; v.wc = wc; v.sz = sz; v.wz = wz;
        v.eres = eres; v.ec = ec; v.ez = ez;
        return v;
    endfunction

    function automatic logic [18:0] ins_of(int tag, logic [7:0] imm);
        return {11'(tag * 37), imm};
    endfunction

    function automatic out_t exp_of(vec_t v, int tag);
        out_t e;
        e.res = v.eres;
        e.b   = v.b;
        e.ins = ins_of(tag, v.imm);
        e.mw  = tag[0];
        e.rw  = tag[1];
        e.rwm = tag[2:1];
        e.c   = v.ec;
        e.z   = v.ez;
        return e;
    endfunction

    task automatic drive(vec_t v, int tag, logic st, logic fl, logic rst);
        @(negedge clk);
        reset               = rst;
        stall               = st;
        flush               = fl;
        ID_EX_A             = v.a;
        ID_EX_B             = v.b;
        ID_EX_instruction   = ins_of(tag, v.imm);
        ID_EX_mem_write     = tag[0];
        ID_EX_reg_write     = tag[1];
        ID_EX_reg_write_mux = tag[2:1];
        ID_EX_alu_op        = v.op;
        ID_EX_alu_in_mux    = v.mux;
        ID_EX_alu_use_carry = v.uc;
        ID_EX_select_c      = v.sc;
        ID_EX_write_c       = v.wc;
        ID_EX_select_z      = v.sz;
        ID_EX_write_z       = v.wz;
    endtask

    task automatic cmp(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step(string n);
        out_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty got 0 expected 1", n);
        end else begin
            e = sbq.pop_front();
            cmp({n, ".res"}, 32'(EX_MEM_result), 32'(e.res));
            cmp({n, ".b"}, 32'(EX_MEM_B), 32'(e.b));
            cmp({n, ".ins"}, 32'(EX_MEM_instruction), 32'(e.ins));
            cmp({n, ".mw"}, 32'(EX_MEM_mem_write), 32'(e.mw));
            cmp({n, ".rw"}, 32'(EX_MEM_reg_write), 32'(e.rw));
            cmp({n, ".rwm"}, 32'(EX_MEM_reg_write_mux), 32'(e.rwm));
            cmp({n, ".c"}, 32'(c_flag), 32'(e.c));
            cmp({n, ".z"}, 32'(z_flag), 32'(e.z));
            last = e;
        end
    endtask

    initial begin
        out_t e;
        vec_t v;
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        ID_EX_A = '0; ID_EX_B = '0; ID_EX_instruction = '0;
        ID_EX_mem_write = 0; ID_EX_reg_write = 0; ID_EX_alu_use_carry = 0;
        ID_EX_alu_in_mux = 0; ID_EX_select_c = 0; ID_EX_select_z = 0;
        ID_EX_write_c = 0; ID_EX_write_z = 0;
        ID_EX_alu_op = '0; ID_EX_reg_write_mux = '0;

        //        op    a      b      imm    mx uc sc wc sz wz res    c  z
        vecs[0]  = mk(3'd0, 8'hF0, 8'h20, 8'h00, 0, 0, 1, 1, 1, 1, 8'h10, 1, 0);
        vecs[1]  = mk(3'd0, 8'h00, 8'h00, 8'h00, 0, 1, 1, 1, 1, 1, 8'h01, 0, 0);
        vecs[2]  = mk(3'd1, 8'h05, 8'h33, 8'h05, 1, 0, 1, 1, 1, 1, 8'h00, 0, 1);
        vecs[3]  = mk(3'd1, 8'h03, 8'h44, 8'h04, 1, 0, 1, 1, 0, 1, 8'hFF, 1, 0);
        vecs[4]  = mk(3'd2, 8'hF0, 8'h0F, 8'h00, 0, 0, 1, 1, 1, 1, 8'h00, 0, 1);
        vecs[5]  = mk(3'd3, 8'h12, 8'h21, 8'h00, 0, 0, 1, 1, 1, 1, 8'h33, 0, 0);
        vecs[6]  = mk(3'd0, 8'hFF, 8'h01, 8'h00, 0, 0, 1, 1, 1, 1, 8'h00, 1, 1);
        vecs[7]  = mk(3'd4, 8'hAA, 8'hAA, 8'h00, 0, 0, 1, 0, 0, 1, 8'h00, 1, 1);
        vecs[8]  = mk(3'd5, 8'h80, 8'h00, 8'h00, 0, 1, 1, 1, 1, 1, 8'h01, 1, 0);
        vecs[9]  = mk(3'd6, 8'h01, 8'h00, 8'h00, 0, 1, 1, 1, 1, 1, 8'h80, 1, 0);
        vecs[10] = mk(3'd7, 8'h55, 8'h77, 8'h00, 1, 0, 1, 1, 1, 1, 8'h00, 0, 1);
        vecs[11] = mk(3'd1, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 1, 0, 1, 8'h01, 0, 0);
        vecs[12] = mk(3'd0, 8'h10, 8'h20, 8'h00, 0, 0, 1, 0, 1, 0, 8'h30, 0, 0);
        vecs[13] = mk(3'd1, 8'h00, 8'h00, 8'h00, 0, 1, 1, 1, 1, 1, 8'h00, 0, 1);

        // reset state
        v = mk(3'd0, 8'h12, 8'h34, 8'h56, 0, 0, 1, 1, 1, 1, 8'h00, 0, 0);
        drive(v, 5, 1'b0, 1'b0, 1'b0);
        e = '0;
        sbq.push_back(e);
        step("reset");

        foreach (vecs[i]) begin
            drive(vecs[i], i, 1'b0, 1'b0, 1'b1);
            sbq.push_back(exp_of(vecs[i], i));
            step($sformatf("vec%0d", i));
        end

        // stalled SHR holds everything, then commits once
        v = mk(3'd6, 8'h81, 8'h09, 8'h00, 0, 0, 1, 1, 0, 1, 8'h40, 1, 0);
        for (int k = 0; k < 3; k++) begin
            drive(v, 20, 1'b1, 1'b0, 1'b1);
            sbq.push_back(last);
            step($sformatf("stall%0d", k));
        end
        drive(v, 20, 1'b0, 1'b0, 1'b1);
        sbq.push_back(exp_of(v, 20));
        step("shr_release");

        // flush with stall: bubble, flags hold (c=1, z=0)
        v = mk(3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 1, 1, 1, 8'h00, 0, 1);
        drive(v, 3, 1'b1, 1'b1, 1'b1);
        e = '0;
        e.c = 1'b1;
        e.z = 1'b0;
        sbq.push_back(e);
        step("flush");

        // reset during stall with c_flag set
        drive(v, 7, 1'b1, 1'b0, 1'b0);
        e = '0;
        sbq.push_back(e);
        step("rst_stall");

        v = mk(3'd0, 8'h01, 8'h01, 8'h00, 0, 1, 1, 1, 1, 1, 8'h02, 0, 0);
        drive(v, 6, 1'b0, 1'b0, 1'b1);
        sbq.push_back(exp_of(v, 6));
        step("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
